// File: rtl/writeback_queue_pkg.sv
// Constants and the write-back entry layout shared by the write-back queue and the register file.
package writeback_queue_pkg;

    localparam int WBQ_DATA_W = 64;
    localparam int WBQ_ADDR_W = 9;
    localparam int WBQ_DEPTH  = 4;

    // One pending register write, laid out as {reg, data}.
    typedef struct packed {
        logic [WBQ_ADDR_W-1:0] rd;
        logic [WBQ_DATA_W-1:0] data;
    } wbq_entry_t;

endpackage

// File: rtl/wbq_fifo.sv
// Circular FIFO for the write-back queue: up to two pushes and one pop per edge,
// per-entry valid bits, and two address-match vectors for hazard detection.
module wbq_fifo
    import writeback_queue_pkg::*;
#(
    parameter int  DATA_W = WBQ_DATA_W,
    parameter int  ADDR_W = WBQ_ADDR_W,
    parameter int  DEPTH  = WBQ_DEPTH,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push_a,
    input  logic [ADDR_W-1:0] i_push_a_reg,
    input  logic [DATA_W-1:0] i_push_a_data,
    input  logic              i_push_b,
    input  logic [ADDR_W-1:0] i_push_b_reg,
    input  logic [DATA_W-1:0] i_push_b_data,
    input  logic              i_pop,
    output logic [ADDR_W-1:0] o_head_reg,
    output logic [DATA_W-1:0] o_head_data,
    output logic [CNT_W-1:0]  o_count,
    input  logic [ADDR_W-1:0] i_cmp_a,
    input  logic [ADDR_W-1:0] i_cmp_b,
    output logic [DEPTH-1:0]  o_match_a,
    output logic [DEPTH-1:0]  o_match_b
);

    logic [ADDR_W-1:0] r_reg  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_tail_b;

    // Push b is only ever issued together with push a, so it lands one slot behind it.
    assign w_tail_b = r_tail + PTR_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (i_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (i_push_a) r_valid[r_tail]   <= 1'b1;
            if (i_push_b) r_valid[w_tail_b] <= 1'b1;
            r_tail  <= r_tail + PTR_W'(i_push_a) + PTR_W'(i_push_b);
            r_count <= r_count + CNT_W'(i_push_a) + CNT_W'(i_push_b) - CNT_W'(i_pop);
        end
    end

    // NOTE: the payload array is deliberately not reset; r_valid alone decides which entries are live.
    always_ff @(posedge i_clk) begin
        if (i_push_a) begin
            r_reg[r_tail]  <= i_push_a_reg;
            r_data[r_tail] <= i_push_a_data;
        end
        if (i_push_b) begin
            r_reg[w_tail_b]  <= i_push_b_reg;
            r_data[w_tail_b] <= i_push_b_data;
        end
    end

    assign o_head_reg  = r_reg[r_head];
    assign o_head_data = r_data[r_head];
    assign o_count     = r_count;

    // NOTE: combinational outputs get a default before the loop so no latch can be inferred.
    always_comb begin
        o_match_a = '0;
        o_match_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_match_a[i] = r_valid[i] && (r_reg[i] == i_cmp_a);
            o_match_b[i] = r_valid[i] && (r_reg[i] == i_cmp_b);
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Write-back queue in front of the register file write port: arbitrates ALU and load
// writes into a FIFO, presents them through a registered output slot, and flags RAW hazards.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DATA_W = WBQ_DATA_W,
    parameter int ADDR_W = WBQ_ADDR_W,
    parameter int DEPTH  = WBQ_DEPTH
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         alu_valid,
    input  logic [ADDR_W-1:0]            alu_reg,
    input  logic [DATA_W-1:0]            alu_data,
    output logic                         alu_ready,
    input  logic                         mem_valid,
    input  logic [ADDR_W-1:0]            mem_reg,
    input  logic [DATA_W-1:0]            mem_data,
    output logic                         mem_ready,
    input  logic                         En,
    output logic [ADDR_W-1:0]            write_reg,
    output logic [DATA_W-1:0]            write_data,
    output logic                         reg_write,
    input  logic [ADDR_W-1:0]            read_reg1,
    input  logic [ADDR_W-1:0]            read_reg2,
    output logic                         hazard1,
    output logic                         hazard2,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]  w_free;
    logic              w_mem_acc;
    logic              w_alu_acc;
    logic              w_push_a;
    logic              w_push_b;
    logic [ADDR_W-1:0] w_push_a_reg;
    logic [DATA_W-1:0] w_push_a_data;
    logic              w_pop;
    logic [ADDR_W-1:0] w_head_reg;
    logic [DATA_W-1:0] w_head_data;
    logic [DEPTH-1:0]  w_match1;
    logic [DEPTH-1:0]  w_match2;

    logic              r_reg_write;
    logic [ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0] r_write_data;

    // Ready looks only at registered occupancy; a same-edge pop never frees a slot early.
    assign w_free    = CNT_W'(DEPTH) - count;
    assign mem_ready = (w_free != '0);
    assign alu_ready = (w_free >= CNT_W'(2)) || ((w_free == CNT_W'(1)) && !mem_valid);
    assign full      = (count == CNT_W'(DEPTH));

    assign w_mem_acc = mem_valid && mem_ready;
    assign w_alu_acc = alu_valid && alu_ready;

    // The load is the older instruction, so it takes the first push lane.
    assign w_push_a      = w_mem_acc || w_alu_acc;
    assign w_push_a_reg  = w_mem_acc ? mem_reg  : alu_reg;
    assign w_push_a_data = w_mem_acc ? mem_data : alu_data;
    assign w_push_b      = w_mem_acc && w_alu_acc;

    assign w_pop = (!r_reg_write || En) && (count != '0);

    wbq_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk         (Clk),
        .i_rst         (Rst),
        .i_push_a      (w_push_a),
        .i_push_a_reg  (w_push_a_reg),
        .i_push_a_data (w_push_a_data),
        .i_push_b      (w_push_b),
        .i_push_b_reg  (alu_reg),
        .i_push_b_data (alu_data),
        .i_pop         (w_pop),
        .o_head_reg    (w_head_reg),
        .o_head_data   (w_head_data),
        .o_count       (count),
        .i_cmp_a       (read_reg1),
        .i_cmp_b       (read_reg2),
        .o_match_a     (w_match1),
        .o_match_b     (w_match2)
    );

    // Output slot: address/data hold their last values once the slot drains.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else if (w_pop) begin
            r_reg_write  <= 1'b1;
            r_write_reg  <= w_head_reg;
            r_write_data <= w_head_data;
        end else if (En) begin
            r_reg_write  <= 1'b0;
        end
    end

    assign reg_write  = r_reg_write;
    assign write_reg  = r_write_reg;
    assign write_data = r_write_data;

    assign hazard1 = (|w_match1) || (r_reg_write && (r_write_reg == read_reg1));
    assign hazard2 = (|w_match2) || (r_reg_write && (r_write_reg == read_reg2));

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the buffer.
`timescale 1ns/1ps
module tb_writeback_queue;
    import writeback_queue_pkg::*;

    localparam int DATA_W = WBQ_DATA_W;
    localparam int ADDR_W = WBQ_ADDR_W;
    localparam int DEPTH  = WBQ_DEPTH;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              Clk = 1'b0;
    logic              Rst;
    logic              alu_valid, mem_valid, En;
    logic [ADDR_W-1:0] alu_reg, mem_reg, read_reg1, read_reg2;
    logic [DATA_W-1:0] alu_data, mem_data;
    logic              alu_ready, mem_ready, reg_write, hazard1, hazard2, full;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [CNT_W-1:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    writeback_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Rst(Rst),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .En(En), .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .read_reg1(read_reg1), .read_reg2(read_reg2), .hazard1(hazard1), .hazard2(hazard2),
        .count(count), .full(full)
    );

    // Register file fed by the DUT's write port.
    logic [DATA_W-1:0] rf_dut [1 << ADDR_W];
    always @(posedge Clk) begin
        if (!Rst && reg_write && En) rf_dut[write_reg] <= write_data;
    end

    // Reference model: ordered list of queued writes plus the presented write.
    wbq_entry_t        m_fifo[$];
    bit                m_slot_v   = 1'b0;
    logic [ADDR_W-1:0] m_slot_reg = '0;
    logic [DATA_W-1:0] m_slot_data = '0;

    function automatic int m_free();
        return DEPTH - m_fifo.size();
    endfunction

    function automatic bit m_mem_ready();
        return m_free() >= 1;
    endfunction

    function automatic bit m_alu_ready(bit mv);
        return (m_free() >= 2) || (m_free() == 1 && !mv);
    endfunction

    function automatic bit m_hazard(logic [ADDR_W-1:0] a);
        foreach (m_fifo[i]) if (m_fifo[i].rd == a) return 1'b1;
        return m_slot_v && (m_slot_reg == a);
    endfunction

    // Advance model and DUT by one rising edge; inputs are sampled before the edge.
    task automatic tick();
        wbq_entry_t e;
        bit mem_acc, alu_acc, pop;
        if (Rst) begin
            m_fifo.delete();
            m_slot_v    = 1'b0;
            m_slot_reg  = '0;
            m_slot_data = '0;
        end else begin
            mem_acc = mem_valid && m_mem_ready();
            alu_acc = alu_valid && m_alu_ready(mem_valid);
            pop     = (!m_slot_v || En) && (m_fifo.size() > 0);
            if (m_slot_v && En) m_slot_v = 1'b0;
            if (pop) begin
                e           = m_fifo.pop_front();
                m_slot_v    = 1'b1;
                m_slot_reg  = e.rd;
                m_slot_data = e.data;
            end
            if (mem_acc) begin e.rd = mem_reg; e.data = mem_data; m_fifo.push_back(e); end
            if (alu_acc) begin e.rd = alu_reg; e.data = alu_data; m_fifo.push_back(e); end
        end
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic drain();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        En        = 1'b1;
        for (int i = 0; i < 4 * DEPTH && (m_slot_v || m_fifo.size() > 0); i++) tick();
        En = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        tick();
        tick();
        Rst = 1'b0;
        #1;
        n_tests++; if (count !== 0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_tests++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_reg_write: got %b want 0", reg_write); end
        n_tests++; if (write_reg !== 0) begin n_fail++; $display("FAIL reset_write_reg: got %0d want 0", write_reg); end
        n_tests++; if (write_data !== 0) begin n_fail++; $display("FAIL reset_write_data: got %h want 0", write_data); end
        n_tests++; if (full !== 1'b0 || alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: full=%b alu_ready=%b mem_ready=%b want 0 1 1", full, alu_ready, mem_ready);
        end
    endtask

    task automatic test_single_write();
        En = 1'b1; alu_valid = 1'b1; alu_reg = 5; alu_data = 64'h1234;
        #1;
        n_tests++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        #1;
        n_tests++; if (count !== 1 || reg_write !== 1'b0) begin
            n_fail++; $display("FAIL single_t0: count=%0d reg_write=%b want 1 0", count, reg_write);
        end
        tick();
        #1;
        n_tests++; if (reg_write !== 1'b1 || write_reg !== 5 || write_data !== 64'h1234) begin
            n_fail++; $display("FAIL single_slot: rw=%b reg=%0d data=%h want 1 5 1234", reg_write, write_reg, write_data);
        end
        tick();
        #1;
        n_tests++; if (rf_dut[5] !== 64'h1234) begin n_fail++; $display("FAIL single_rf: got %h want 1234", rf_dut[5]); end
        n_tests++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b want 0", reg_write); end
        En = 1'b0;
    endtask

    task automatic test_same_edge_order();
        En = 1'b0;
        mem_valid = 1'b1; mem_reg = 3; mem_data = 64'hAA;
        alu_valid = 1'b1; alu_reg = 3; alu_data = 64'hBB;
        read_reg1 = 3;
        #1;
        n_tests++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
            n_fail++; $display("FAIL order_ready: mem=%b alu=%b want 1 1", mem_ready, alu_ready);
        end
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        #1;
        n_tests++; if (count !== 2 || hazard1 !== 1'b1) begin
            n_fail++; $display("FAIL order_count: count=%0d hazard1=%b want 2 1", count, hazard1);
        end
        En = 1'b1;
        tick();
        #1;
        n_tests++; if (reg_write !== 1'b1 || write_data !== 64'hAA) begin
            n_fail++; $display("FAIL order_first: rw=%b data=%h want 1 aa", reg_write, write_data);
        end
        tick();
        #1;
        n_tests++; if (reg_write !== 1'b1 || write_data !== 64'hBB) begin
            n_fail++; $display("FAIL order_second: rw=%b data=%h want 1 bb", reg_write, write_data);
        end
        tick();
        #1;
        n_tests++; if (reg_write !== 1'b0 || rf_dut[3] !== 64'hBB) begin
            n_fail++; $display("FAIL order_final: rw=%b rf3=%h want 0 bb", reg_write, rf_dut[3]);
        end
        En = 1'b0;
    endtask

    task automatic test_fill();
        int nxt = 1;
        int acc = 0;
        bit rdy;
        En = 1'b0; alu_valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            alu_reg = ADDR_W'(nxt); alu_data = DATA_W'(100 + nxt);
            #1;
            rdy = alu_ready;
            tick();
            if (rdy) begin nxt++; acc++; end
        end
        #1;
        n_tests++; if (acc !== 5) begin n_fail++; $display("FAIL fill_accepted: got %0d want 5", acc); end
        n_tests++; if (full !== 1'b1 || count !== DEPTH || alu_ready !== 1'b0) begin
            n_fail++; $display("FAIL fill_full: full=%b count=%0d alu_ready=%b want 1 %0d 0", full, count, alu_ready, DEPTH);
        end
        n_tests++; if (reg_write !== 1'b1 || write_reg !== 1) begin
            n_fail++; $display("FAIL fill_slot: rw=%b reg=%0d want 1 1", reg_write, write_reg);
        end
        En = 1'b1;
        #1;
        n_tests++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL fill_no_early_ready: got %b want 0", alu_ready); end
        tick();
        En = 1'b0;
        #1;
        n_tests++; if (alu_ready !== 1'b1 || alu_reg !== 6) begin
            n_fail++; $display("FAIL fill_reg6_ready: ready=%b reg=%0d want 1 6", alu_ready, alu_reg);
        end
        tick();
        alu_valid = 1'b0;
        #1;
        n_tests++; if (count !== DEPTH || write_reg !== 2) begin
            n_fail++; $display("FAIL fill_after: count=%0d reg=%0d want %0d 2", count, write_reg, DEPTH);
        end
        drain();
    endtask

    task automatic test_priority();
        logic [ADDR_W-1:0] exp_order [5];
        exp_order[0] = 21; exp_order[1] = 22; exp_order[2] = 23; exp_order[3] = 30; exp_order[4] = 31;
        En = 1'b0; alu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_reg = ADDR_W'(20 + i); alu_data = DATA_W'(i);
            tick();
        end
        mem_valid = 1'b1; mem_reg = 30; mem_data = 64'h30;
        alu_reg = 31; alu_data = 64'h31;
        #1;
        n_tests++; if (count !== DEPTH - 1 || mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
            n_fail++; $display("FAIL prio_one_free: count=%0d mem=%b alu=%b want %0d 1 0", count, mem_ready, alu_ready, DEPTH - 1);
        end
        tick();
        mem_valid = 1'b0;
        #1;
        n_tests++; if (count !== DEPTH || alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            n_fail++; $display("FAIL prio_full: count=%0d alu=%b mem=%b want %0d 0 0", count, alu_ready, mem_ready, DEPTH);
        end
        En = 1'b1;
        tick();
        En = 1'b0;
        #1;
        n_tests++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL prio_alu_later: got %b want 1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        En = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_tests++; if (reg_write !== 1'b1 || write_reg !== exp_order[k]) begin
                n_fail++; $display("FAIL prio_order_%0d: rw=%b reg=%0d want 1 %0d", k, reg_write, write_reg, exp_order[k]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_hazard();
        En = 1'b0; alu_valid = 1'b1; alu_reg = 7; alu_data = 64'h77;
        read_reg1 = 7; read_reg2 = 8;
        #1;
        n_tests++; if (hazard1 !== 1'b0) begin n_fail++; $display("FAIL haz_incoming: got %b want 0", hazard1); end
        tick();
        alu_valid = 1'b0;
        #1;
        n_tests++; if (hazard1 !== 1'b1 || hazard2 !== 1'b0) begin
            n_fail++; $display("FAIL haz_fifo: h1=%b h2=%b want 1 0", hazard1, hazard2);
        end
        tick();
        #1;
        n_tests++; if (hazard1 !== 1'b1 || reg_write !== 1'b1) begin
            n_fail++; $display("FAIL haz_slot: h1=%b rw=%b want 1 1", hazard1, reg_write);
        end
        En = 1'b1;
        tick();
        En = 1'b0;
        #1;
        n_tests++; if (hazard1 !== 1'b0) begin n_fail++; $display("FAIL haz_cleared: got %b want 0", hazard1); end
        alu_valid = 1'b1; alu_reg = 0; alu_data = 64'h0; read_reg2 = 0;
        tick();
        alu_valid = 1'b0;
        #1;
        n_tests++; if (hazard2 !== 1'b1) begin n_fail++; $display("FAIL haz_reg0: got %b want 1", hazard2); end
        drain();
        #1;
        n_tests++; if (hazard2 !== 1'b0) begin n_fail++; $display("FAIL haz_reg0_cleared: got %b want 0", hazard2); end
    endtask

    task automatic test_reset_midflight();
        En = 1'b0; alu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_reg = ADDR_W'(40 + i); alu_data = DATA_W'(40 + i);
            tick();
        end
        read_reg1 = 41; read_reg2 = 40;
        #1;
        n_tests++; if (count !== 3 || reg_write !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_setup: count=%0d rw=%b want 3 1", count, reg_write);
        end
        Rst = 1'b1; alu_reg = 44; alu_data = 64'h44;
        tick();
        Rst = 1'b0; alu_valid = 1'b0;
        #1;
        n_tests++; if (count !== 0 || reg_write !== 1'b0 || write_reg !== 0) begin
            n_fail++; $display("FAIL rstmid_state: count=%0d rw=%b reg=%0d want 0 0 0", count, reg_write, write_reg);
        end
        n_tests++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_hazard: h1=%b h2=%b want 0 0", hazard1, hazard2);
        end
        read_reg1 = 44;
        tick();
        #1;
        n_tests++; if (count !== 0 || reg_write !== 1'b0 || hazard1 !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_not_stored: count=%0d rw=%b h1=%b want 0 0 0", count, reg_write, hazard1);
        end
    endtask

    task automatic test_random();
        bit mem_acc, alu_acc;
        for (int c = 0; c < 800; c++) begin
            Rst = ($urandom_range(0, 99) == 0);
            if (!mem_valid && $urandom_range(0, 2) == 0) begin
                mem_valid = 1'b1; mem_reg = ADDR_W'($urandom_range(0, 7)); mem_data = {$urandom, $urandom};
            end
            if (!alu_valid && $urandom_range(0, 1) == 0) begin
                alu_valid = 1'b1; alu_reg = ADDR_W'($urandom_range(0, 7)); alu_data = {$urandom, $urandom};
            end
            En = (c < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            read_reg1 = ADDR_W'($urandom_range(0, 7));
            read_reg2 = ADDR_W'($urandom_range(0, 7));
            #1;
            n_tests++; if (mem_ready !== m_mem_ready()) begin n_fail++; $display("FAIL rand_mem_ready c%0d: got %b want %b", c, mem_ready, m_mem_ready()); end
            n_tests++; if (alu_ready !== m_alu_ready(mem_valid)) begin n_fail++; $display("FAIL rand_alu_ready c%0d: got %b want %b", c, alu_ready, m_alu_ready(mem_valid)); end
            n_tests++; if (reg_write !== m_slot_v) begin n_fail++; $display("FAIL rand_reg_write c%0d: got %b want %b", c, reg_write, m_slot_v); end
            n_tests++; if (write_reg !== m_slot_reg) begin n_fail++; $display("FAIL rand_write_reg c%0d: got %0d want %0d", c, write_reg, m_slot_reg); end
            n_tests++; if (write_data !== m_slot_data) begin n_fail++; $display("FAIL rand_write_data c%0d: got %h want %h", c, write_data, m_slot_data); end
            n_tests++; if (count !== CNT_W'(m_fifo.size())) begin n_fail++; $display("FAIL rand_count c%0d: got %0d want %0d", c, count, m_fifo.size()); end
            n_tests++; if (full !== (m_fifo.size() == DEPTH)) begin n_fail++; $display("FAIL rand_full c%0d: got %b want %b", c, full, m_fifo.size() == DEPTH); end
            n_tests++; if (hazard1 !== m_hazard(read_reg1)) begin n_fail++; $display("FAIL rand_hazard1 c%0d: got %b want %b", c, hazard1, m_hazard(read_reg1)); end
            n_tests++; if (hazard2 !== m_hazard(read_reg2)) begin n_fail++; $display("FAIL rand_hazard2 c%0d: got %b want %b", c, hazard2, m_hazard(read_reg2)); end
            mem_acc = mem_valid && m_mem_ready() && !Rst;
            alu_acc = alu_valid && m_alu_ready(mem_valid) && !Rst;
            tick();
            if (mem_acc) mem_valid = 1'b0;
            if (alu_acc) alu_valid = 1'b0;
        end
        Rst = 1'b0;
        drain();
    endtask

    initial begin
        Rst = 1'b1; En = 1'b0;
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
        read_reg1 = '0; read_reg2 = '0;
        test_reset();
        test_single_write();
        test_same_edge_order();
        test_fill();
        test_priority();
        test_hazard();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Write-back buffer sitting directly upstream of the register file write port.
- Collects register write requests from two producers: the ALU result path and the load (memory) return path.
- Queues requests in order and presents them one at a time on write_reg / write_data / reg_write, using the register file's En as the consume strobe.
- Flags pending writes to the two read addresses so the operand-fetch stage can stall on read-after-write.

Parameters:
- DATA_W, 64, data width (matches register file entries)
- ADDR_W, 9, register address width
- DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  synchronous active-high reset
- alu_valid  in  1  ALU write request
- alu_reg  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request accepted this edge when high with alu_valid
- mem_valid  in  1  load write request
- mem_reg  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load request accepted this edge when high with mem_valid
- En  in  1  register file enable; consumes the presented write
- write_reg  out  ADDR_W  to register file
- write_data  out  DATA_W  to register file
- reg_write  out  1  presented write valid
- read_reg1  in  ADDR_W  snooped read address 1
- read_reg2  in  ADDR_W  snooped read address 2
- hazard1  out  1  pending write to read_reg1
- hazard2  out  1  pending write to read_reg2
- count  out  $clog2(DEPTH+1)  FIFO occupancy, excluding the output slot
- full  out  1  count == DEPTH

Behaviour:
- Storage is a DEPTH-entry circular FIFO (head/tail pointers wrap modulo DEPTH) plus one output slot. The output slot drives write_reg, write_data and reg_write as registers. Total capacity is DEPTH+1.
- Reset:
  - count=0, pointers=0, reg_write=0, write_reg=0, write_data=0.
  - All FIFO valid state cleared; in-flight entries are dropped.
  - Reset dominates any same-cycle push or consume.
- Ready computation:
  - Ready depends only on the registered count plus mem_valid. It never depends on a same-cycle pop.
  - free = DEPTH - count.
  - mem_ready = (free >= 1).
  - alu_ready = (free >= 2) || (free == 1 && !mem_valid).
  - Fixed priority goes to mem when only one slot is free.
- Push order: when both producers are accepted on the same edge, the mem entry is enqueued ahead of the alu entry (the load is the older instruction).
- Output slot:
  - Consumed at an edge where reg_write=1 and En=1; the register file writes on that same edge.
  - reg_write=1 with En=0 holds write_reg and write_data stable.
  - The slot loads the FIFO head at an edge where (slot empty or being consumed) and count > 0. reg_write is then 1 in the next cycle.
  - If the slot empties and the FIFO is empty, reg_write=0 and write_reg/write_data hold their last values.
- Latency:
  - A request accepted at edge t enters the FIFO at t.
  - With an empty output slot it is loaded at t+1, so reg_write is high in cycle t+1..t+2.
  - With En=1 the register file writes at edge t+2.
  - There is no FIFO bypass.
- count updates by pushes minus the head pop each edge. A simultaneous push and pop at full is impossible, because ready excludes the pop.
- Hazards (combinational):
  - hazard1 = read_reg1 equals the address of any valid FIFO entry, or equals write_reg while reg_write=1. hazard2 is defined the same way for read_reg2.
  - Same-cycle incoming requests are not included; upstream must account for those.
  - No register is exempt, including address 0.
- Producers must hold valid, reg and data stable until accepted.

Decomposition:
- Shared package/header: DATA_W, ADDR_W defaults, plus the common entry layout {reg, data}. The register file uses the same constants.
- One sub-module, wbq_fifo:
  - DEPTH-entry storage with 0/1/2 push and 0/1 pop per cycle, count, and per-entry valid bits.
  - Per-entry address compare producing two match vectors.
- Top level holds the arbitration, the output slot and the hazard OR-reduction.

Test Plan:
1. Rst, then alu push reg=5 data=0x1234 at edge t, En=1 -> reg_write=1, write_reg=5 in cycle t+1..t+2; register file read of 5 returns 0x1234 after edge t+2.
2. Empty queue, En=0, mem(reg 3, 0xAA) and alu(reg 3, 0xBB) same edge -> both ready=1, count=2. Raise En -> writes appear in order 0xAA then 0xBB; final reg 3 = 0xBB.
3. En=0, alu_valid held high with distinct regs 1..6 -> 5 accepted (1 into output slot, 4 in FIFO), full=1, alu_ready=0. reg 6 accepted one edge after En pulses high.
4. count=DEPTH-1, both valid -> mem accepted, alu_ready=0. alu accepted the following edge once free >= 1 and mem_valid=0.
5. Entry reg 7 pending, read_reg1=7, read_reg2=8 -> hazard1=1, hazard2=0. After reg 7 is consumed with En=1 -> hazard1=0 in the next cycle.
6. 3 entries queued plus slot occupied, assert Rst with alu_valid=1 -> next cycle count=0, reg_write=0, write_reg=0, hazard1=hazard2=0; the pushed request is not stored.
